mips_cpu_writeback_arbiter: RTL and testbench
=============================================

Name: mips_cpu_writeback_arbiter

Overview:
Write-side initiator for the CPU register file. It merges results from the single-cycle ALU path and from the multi-cycle unit (loads, mul/div) into the register file's single write port (write_enable, write_reg, write_data). Multi-cycle results are buffered in a small FIFO. A per-register pending scoreboard lets decode stall on registers whose multi-cycle result has not yet been written.

Parameters:
FIFO_DEPTH, 4, multi-cycle result buffer entries; power of 2, >= 2
STARVE_LIMIT, 4, consecutive cycles the FIFO head may lose arbitration before it is forced through; >= 1

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high
alu_valid  input  1  ALU result present
alu_reg  input  5  ALU destination register
alu_data  input  32  ALU result
alu_stall  output  1  ALU result not consumed this cycle; producer holds alu_* stable
mc_valid  input  1  multi-cycle result present
mc_ready  output  1  FIFO can accept a result
mc_reg  input  5  multi-cycle destination register
mc_data  input  32  multi-cycle result
issue_valid  input  1  multi-cycle op issued this cycle
issue_reg  input  5  destination register of the issued op
query_reg_1  input  5  decode source register 1
query_reg_2  input  5  decode source register 2
busy_1  output  1  query_reg_1 has a pending multi-cycle write
busy_2  output  1  query_reg_2 has a pending multi-cycle write
rf_write_enable  output  1  to register file write_enable
rf_write_reg  output  5  to register file write_reg
rf_write_data  output  32  to register file write_data
sb_error  output  1  sticky: issue to an already-pending register
fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (synchronous) clears FIFO, scoreboard, starvation counter and sb_error. At the next edge all outputs are 0 except mc_ready. mc_ready is low while reset is high and high afterwards. Reset mid-operation discards buffered results.
- mc_ready = !full && !reset. A push happens on mc_valid && mc_ready. Full blocks a push even when a pop occurs in the same cycle. mc_valid is ignored while mc_ready is low.
- Arbitration is evaluated combinationally each cycle. The winner is registered onto rf_* at the next edge, so latency is 1 cycle from input to rf_write_enable.
  - forced = (starve_cnt == STARVE_LIMIT) && !empty.
  - If forced: pop the FIFO head; alu_stall = alu_valid.
  - Else if alu_valid: take the ALU result; alu_stall = 0.
  - Else if !empty: pop the FIFO head.
  - Else: rf_write_enable = 0 next cycle.
- starve_cnt increments when the FIFO is non-empty and not popped. It resets to 0 on any pop or when the FIFO is empty, and saturates at STARVE_LIMIT.
- Register 0: a winner with reg == 0 produces rf_write_enable = 0. The FIFO entry is still popped and the ALU result is still consumed.
- Scoreboard is a 32-bit pending vector. Bit 0 is never set.
  - Set by issue_valid.
  - Cleared when a popped FIFO entry for that register is registered to rf_*.
  - Same-cycle set and clear of the same register: set wins.
  - issue_valid to an already-pending register sets sb_error; the bit stays set.
  - ALU writes never touch the scoreboard.
- busy_n = pending[query_reg_n]. It is combinational, and 0 for register 0.
- rf_write_data is a full 32-bit pass-through with no arithmetic. Push and pop in the same non-full, non-empty cycle leave fifo_count unchanged.

Optional Feature:
WB_BYPASS_EN
- Defined: adds outputs fwd_hit_1, fwd_hit_2 (1 bit) and fwd_data_1, fwd_data_2 (32 bits).
  - fwd_hit_n = rf_write_enable && rf_write_reg == query_reg_n && query_reg_n != 0.
  - fwd_data_n = rf_write_data.
  - This covers the cycle in which the register file still returns the old value.
- Undefined: these ports do not exist. Decode waits one extra cycle after a pending register clears.

Decomposition:
- Package mips_cpu_pkg holds:
  - REG_ADDR_W = 5 and DATA_W = 32.
  - typedef wb_req_t, a struct of reg_addr and data.
- One sub-module, mips_cpu_wb_fifo: parameterised FIFO of wb_req_t with push, pop, full, empty and count.
- Arbitration, scoreboard and starvation logic stay in the top module.

Test Plan:
- After reset, alu_valid=1, alu_reg=8, alu_data=0x1234 -> next cycle rf_write_enable=1, rf_write_reg=8, rf_write_data=0x1234; alu_stall=0.
- issue reg 9, then mc result (9, 0xCAFE) with alu_valid=0 -> busy for reg 9 is high until the write cycle; rf_write_reg=9, rf_write_data=0xCAFE; busy clears on the same edge.
- FIFO_DEPTH=4, push 5 mc results with alu_valid held high -> mc_ready low after 4 pushes; fifo_count=4; after 4 ALU-won cycles, alu_stall=1 for one cycle and the FIFO head is written.
- alu_reg=0, alu_data=0xFFFF_FFFF -> rf_write_enable stays 0; FIFO entry with reg 0 is popped and fifo_count decrements with no write.
- issue reg 5 twice without completion -> sb_error=1 and stays 1 until reset; reset mid-burst with fifo_count=3 -> fifo_count=0, busy all 0, rf_write_enable=0.
- WB_BYPASS_EN defined, rf write reg 7 = 0x55 while query_reg_1=7 -> fwd_hit_1=1, fwd_data_1=0x55; query_reg_1=0 -> fwd_hit_1=0.

Source files
------------

// File: rtl/mips_cpu_pkg.sv
// Shared widths and the write-back request record used by the CPU write-back path.
package mips_cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

endpackage

// File: rtl/mips_cpu_writeback_arbiter_if.sv
// Write-back arbiter bus: ALU/multi-cycle producers, scoreboard queries, register-file port.
// Defining WB_BYPASS_EN adds the fwd_hit_n/fwd_data_n forwarding outputs.
interface mips_cpu_writeback_arbiter_if #(
  parameter int FIFO_DEPTH = 4
);
  import mips_cpu_pkg::*;

  logic                         alu_valid;
  logic [REG_ADDR_W-1:0]        alu_reg;
  logic [DATA_W-1:0]            alu_data;
  logic                         alu_stall;
  logic                         mc_valid;
  logic                         mc_ready;
  logic [REG_ADDR_W-1:0]        mc_reg;
  logic [DATA_W-1:0]            mc_data;
  logic                         issue_valid;
  logic [REG_ADDR_W-1:0]        issue_reg;
  logic [REG_ADDR_W-1:0]        query_reg_1;
  logic [REG_ADDR_W-1:0]        query_reg_2;
  logic                         busy_1;
  logic                         busy_2;
  logic                         rf_write_enable;
  logic [REG_ADDR_W-1:0]        rf_write_reg;
  logic [DATA_W-1:0]            rf_write_data;
  logic                         sb_error;
  logic [$clog2(FIFO_DEPTH):0]  fifo_count;
`ifdef WB_BYPASS_EN
  logic                         fwd_hit_1;
  logic                         fwd_hit_2;
  logic [DATA_W-1:0]            fwd_data_1;
  logic [DATA_W-1:0]            fwd_data_2;
`endif

  // Arbiter side.
  modport slave (
`ifdef WB_BYPASS_EN
    output fwd_hit_1, fwd_hit_2, fwd_data_1, fwd_data_2,
`endif
    input  alu_valid, alu_reg, alu_data, mc_valid, mc_reg, mc_data,
    input  issue_valid, issue_reg, query_reg_1, query_reg_2,
    output alu_stall, mc_ready, busy_1, busy_2,
    output rf_write_enable, rf_write_reg, rf_write_data, sb_error, fifo_count
  );

  // Producer / decode / register-file side.
  modport master (
`ifdef WB_BYPASS_EN
    input  fwd_hit_1, fwd_hit_2, fwd_data_1, fwd_data_2,
`endif
    output alu_valid, alu_reg, alu_data, mc_valid, mc_reg, mc_data,
    output issue_valid, issue_reg, query_reg_1, query_reg_2,
    input  alu_stall, mc_ready, busy_1, busy_2,
    input  rf_write_enable, rf_write_reg, rf_write_data, sb_error, fifo_count
  );

endinterface

// File: rtl/mips_cpu_wb_fifo.sv
// Small power-of-two FIFO buffering multi-cycle write-back results.
module mips_cpu_wb_fifo
  import mips_cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  wb_req_t                  data_i,
  output wb_req_t                  data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_req_t            mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mips_cpu_writeback_arbiter.sv
// Merges ALU and multi-cycle results onto the single register-file write port and
// tracks pending multi-cycle destinations. Optional forwarding outputs: WB_BYPASS_EN.
module mips_cpu_writeback_arbiter
  import mips_cpu_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  mips_cpu_writeback_arbiter_if.slave  bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

  wb_req_t               mc_req, fifo_head, winner;
  logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic                  forced, alu_take;
  logic [CNT_W-1:0]      fifo_count;
  logic [SC_W-1:0]       starve_q, starve_d;
  logic [NUM_REGS-1:0]   pending_q, pending_d;
  logic                  sb_error_q, sb_error_d;
  logic                  rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0] rf_reg_q;
  logic [DATA_W-1:0]     rf_data_q;

  assign bus.mc_ready = !fifo_full && !reset;
  assign fifo_push    = bus.mc_valid && bus.mc_ready;

  always_comb begin
    mc_req.reg_addr = bus.mc_reg;
    mc_req.data     = bus.mc_data;
  end

  mips_cpu_wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  (mc_req),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // A starved FIFO head pre-empts the ALU, which then has to hold its result.
  always_comb begin
    forced   = (starve_q == STARVE_MAX) && !fifo_empty;
    fifo_pop = !fifo_empty && (forced || !bus.alu_valid);
    alu_take = bus.alu_valid && !forced;

    winner.reg_addr = bus.alu_reg;
    winner.data     = bus.alu_data;
    if (fifo_pop) begin
      winner = fifo_head;
    end
    rf_we_d = (fifo_pop || alu_take) && (winner.reg_addr != '0);

    starve_d = starve_q;
    if (fifo_empty || fifo_pop) begin
      starve_d = '0;
    end else if (starve_q != STARVE_MAX) begin
      starve_d = starve_q + SC_W'(1);
    end
  end

  // Clear before set so a same-cycle issue to the retiring register keeps it pending.
  always_comb begin
    pending_d = pending_q;
    if (fifo_pop) begin
      pending_d[fifo_head.reg_addr] = 1'b0;
    end
    if (bus.issue_valid) begin
      pending_d[bus.issue_reg] = 1'b1;
    end
    pending_d[0] = 1'b0;

    sb_error_d = sb_error_q ||
                 (bus.issue_valid && (bus.issue_reg != '0) && pending_q[bus.issue_reg]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q   <= '0;
      pending_q  <= '0;
      sb_error_q <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_reg_q   <= '0;
      rf_data_q  <= '0;
    end else begin
      starve_q   <= starve_d;
      pending_q  <= pending_d;
      sb_error_q <= sb_error_d;
      rf_we_q    <= rf_we_d;
      rf_reg_q   <= winner.reg_addr;
      rf_data_q  <= winner.data;
    end
  end

  assign bus.alu_stall       = bus.alu_valid && forced;
  assign bus.busy_1          = pending_q[bus.query_reg_1];
  assign bus.busy_2          = pending_q[bus.query_reg_2];
  assign bus.rf_write_enable = rf_we_q;
  assign bus.rf_write_reg    = rf_reg_q;
  assign bus.rf_write_data   = rf_data_q;
  assign bus.sb_error        = sb_error_q;
  assign bus.fifo_count      = fifo_count;

`ifdef WB_BYPASS_EN
  // Covers the cycle where the register file still returns the pre-write value.
  assign bus.fwd_hit_1  = rf_we_q && (rf_reg_q == bus.query_reg_1) && (bus.query_reg_1 != '0);
  assign bus.fwd_hit_2  = rf_we_q && (rf_reg_q == bus.query_reg_2) && (bus.query_reg_2 != '0);
  assign bus.fwd_data_1 = rf_data_q;
  assign bus.fwd_data_2 = rf_data_q;
`endif

endmodule

// File: tb/tb_mips_cpu_writeback_arbiter.sv
// Self-checking bench for mips_cpu_writeback_arbiter: expected register-file writes
// are queued as stimulus is driven and popped by a monitor whenever a write appears.
module tb_mips_cpu_writeback_arbiter;
  import mips_cpu_pkg::*;

  localparam int FIFO_DEPTH   = 4;
  localparam int STARVE_LIMIT = 4;
  localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mips_cpu_writeback_arbiter_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus_if ();

  mips_cpu_writeback_arbiter #(
    .FIFO_DEPTH   (FIFO_DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int      checks   = 0;
  int      failures = 0;
  wb_req_t expQ[$];
  wb_req_t monExp;

  function automatic wb_req_t mkReq(input logic [4:0] r, input logic [31:0] d);
    wb_req_t q;
    q.reg_addr = r;
    q.data     = d;
    return q;
  endfunction

  // Every register-file write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus_if.rf_write_enable === 1'b1) begin
      checks++;
      if (expQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_write: got reg %0d data %h, required no write",
                 bus_if.rf_write_reg, bus_if.rf_write_data);
      end else begin
        monExp = expQ.pop_front();
        if (bus_if.rf_write_reg !== monExp.reg_addr || bus_if.rf_write_data !== monExp.data) begin
          failures++;
          $display("[TB] FAIL write_order: got reg %0d data %h, required reg %0d data %h",
                   bus_if.rf_write_reg, bus_if.rf_write_data, monExp.reg_addr, monExp.data);
        end
      end
    end
  end

  task automatic clearInputs();
    bus_if.alu_valid   = 1'b0;
    bus_if.alu_reg     = '0;
    bus_if.alu_data    = '0;
    bus_if.mc_valid    = 1'b0;
    bus_if.mc_reg      = '0;
    bus_if.mc_data     = '0;
    bus_if.issue_valid = 1'b0;
    bus_if.issue_reg   = '0;
    bus_if.query_reg_1 = '0;
    bus_if.query_reg_2 = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clearInputs();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus_if.mc_ready !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_mc_ready_low: got %b, required 0", bus_if.mc_ready);
    end
    checks++;
    if (bus_if.fifo_count !== CNT_W'(0)) begin
      failures++; $display("[TB] FAIL reset_fifo_count: got %0d, required 0", bus_if.fifo_count);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus_if.mc_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL post_reset_mc_ready: got %b, required 1", bus_if.mc_ready);
    end
    @(posedge clk); #1;
    checks++;
    if ({bus_if.rf_write_enable, bus_if.sb_error, bus_if.alu_stall, bus_if.busy_1, bus_if.busy_2} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got we=%b err=%b stall=%b busy=%b%b, required all 0",
               bus_if.rf_write_enable, bus_if.sb_error, bus_if.alu_stall, bus_if.busy_1, bus_if.busy_2);
    end
  endtask

  task automatic test_alu_write();
    bus_if.alu_valid = 1'b1;
    bus_if.alu_reg   = 5'd8;
    bus_if.alu_data  = 32'h1234;
    expQ.push_back(mkReq(5'd8, 32'h1234));
    #1;
    checks++;
    if (bus_if.alu_stall !== 1'b0) begin
      failures++; $display("[TB] FAIL alu_no_stall: got %b, required 0", bus_if.alu_stall);
    end
    @(posedge clk); #1;
    bus_if.alu_valid = 1'b0;
    checks++;
    if (bus_if.rf_write_enable !== 1'b1) begin
      failures++; $display("[TB] FAIL alu_latency: got we=%b, required 1", bus_if.rf_write_enable);
    end
    @(posedge clk); #1;
    checks++;
    if (bus_if.rf_write_enable !== 1'b0 || expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL alu_single_write: got we=%b pending=%0d, required we=0 pending=0",
               bus_if.rf_write_enable, expQ.size());
    end
  endtask

  task automatic test_mc_scoreboard();
    bus_if.query_reg_1 = 5'd9;
    bus_if.query_reg_2 = 5'd9;
    bus_if.issue_valid = 1'b1;
    bus_if.issue_reg   = 5'd9;
    #1;
    checks++;
    if (bus_if.busy_1 !== 1'b0) begin
      failures++; $display("[TB] FAIL busy_before_issue: got %b, required 0", bus_if.busy_1);
    end
    @(posedge clk); #1;
    bus_if.issue_valid = 1'b0;
    checks++;
    if (bus_if.busy_1 !== 1'b1 || bus_if.busy_2 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL busy_after_issue: got %b%b, required 11", bus_if.busy_1, bus_if.busy_2);
    end
    bus_if.mc_valid = 1'b1;
    bus_if.mc_reg   = 5'd9;
    bus_if.mc_data  = 32'hCAFE;
    expQ.push_back(mkReq(5'd9, 32'hCAFE));
    @(posedge clk); #1;
    bus_if.mc_valid = 1'b0;
    checks++;
    if (bus_if.fifo_count !== CNT_W'(1) || bus_if.busy_1 !== 1'b1 || bus_if.rf_write_enable !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mc_buffered: got count=%0d busy=%b we=%b, required count=1 busy=1 we=0",
               bus_if.fifo_count, bus_if.busy_1, bus_if.rf_write_enable);
    end
    @(posedge clk); #1;
    checks++;
    if (bus_if.rf_write_enable !== 1'b1 || bus_if.busy_1 !== 1'b0 || bus_if.busy_2 !== 1'b0 ||
        bus_if.fifo_count !== CNT_W'(0)) begin
      failures++;
      $display("[TB] FAIL mc_retire: got we=%b busy=%b%b count=%0d, required we=1 busy=00 count=0",
               bus_if.rf_write_enable, bus_if.busy_1, bus_if.busy_2, bus_if.fifo_count);
    end
    @(posedge clk); #1;
    checks++;
    if (expQ.size() != 0) begin
      failures++; $display("[TB] FAIL mc_drained: got %0d pending, required 0", expQ.size());
    end
  endtask

  task automatic test_back_to_back();
    bus_if.mc_valid = 1'b1;
    bus_if.mc_reg   = 5'h11;
    bus_if.mc_data  = 32'h0000_0001;
    expQ.push_back(mkReq(5'h11, 32'h0000_0001));
    @(posedge clk); #1;
    checks++;
    if (bus_if.fifo_count !== CNT_W'(1)) begin
      failures++; $display("[TB] FAIL b2b_first_push: got %0d, required 1", bus_if.fifo_count);
    end
    bus_if.mc_reg  = 5'h12;
    bus_if.mc_data = 32'h0000_0002;
    expQ.push_back(mkReq(5'h12, 32'h0000_0002));
    @(posedge clk); #1;
    bus_if.mc_valid = 1'b0;
    checks++;
    if (bus_if.fifo_count !== CNT_W'(1)) begin
      failures++; $display("[TB] FAIL b2b_push_pop_count: got %0d, required 1", bus_if.fifo_count);
    end
    @(posedge clk); #1;
    checks++;
    if (bus_if.fifo_count !== CNT_W'(0)) begin
      failures++; $display("[TB] FAIL b2b_empty: got %0d, required 0", bus_if.fifo_count);
    end
    @(posedge clk); #1;
    checks++;
    if (expQ.size() != 0) begin
      failures++; $display("[TB] FAIL b2b_drained: got %0d pending, required 0", expQ.size());
    end
  endtask

  task automatic test_starvation();
    int ai = 0;
    int mi = 0;
    int popIdx = 0;
    logic stalled, accepted;
    logic expReady [7];
    logic expStall [7];
    expReady = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    expStall = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int c = 0; c < 7; c++) begin
      bus_if.alu_valid = 1'b1;
      bus_if.alu_reg   = 5'(10 + ai);
      bus_if.alu_data  = 32'hA000 + 32'(ai);
      bus_if.mc_valid  = (mi < 5);
      bus_if.mc_reg    = 5'(20 + mi);
      bus_if.mc_data   = 32'hB000 + 32'(mi);
      if (expStall[c]) begin
        expQ.push_back(mkReq(5'(20 + popIdx), 32'hB000 + 32'(popIdx)));
        popIdx++;
      end else begin
        expQ.push_back(mkReq(5'(10 + ai), 32'hA000 + 32'(ai)));
      end
      #1;
      checks++;
      if (bus_if.mc_ready !== expReady[c]) begin
        failures++;
        $display("[TB] FAIL starve_mc_ready[%0d]: got %b, required %b", c, bus_if.mc_ready, expReady[c]);
      end
      checks++;
      if (bus_if.alu_stall !== expStall[c]) begin
        failures++;
        $display("[TB] FAIL starve_alu_stall[%0d]: got %b, required %b", c, bus_if.alu_stall, expStall[c]);
      end
      stalled  = bus_if.alu_stall;
      accepted = bus_if.mc_ready && bus_if.mc_valid;
      @(posedge clk); #1;
      if (!stalled) ai++;
      if (accepted) mi++;
      if (c == 3 || c == 6) begin
        checks++;
        if (bus_if.fifo_count !== CNT_W'(4)) begin
          failures++;
          $display("[TB] FAIL starve_full_count[%0d]: got %0d, required 4", c, bus_if.fifo_count);
        end
      end
    end
    bus_if.alu_valid = 1'b0;
    bus_if.mc_valid  = 1'b0;
    for (int p = popIdx; p < 5; p++) begin
      expQ.push_back(mkReq(5'(20 + p), 32'hB000 + 32'(p)));
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (bus_if.fifo_count !== CNT_W'(0)) begin
      failures++; $display("[TB] FAIL starve_drain_count: got %0d, required 0", bus_if.fifo_count);
    end
    @(posedge clk); #1;
    checks++;
    if (expQ.size() != 0) begin
      failures++; $display("[TB] FAIL starve_drained: got %0d pending, required 0", expQ.size());
    end
  endtask

  task automatic test_reg_zero();
    bus_if.alu_valid = 1'b1;
    bus_if.alu_reg   = 5'd0;
    bus_if.alu_data  = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (bus_if.alu_stall !== 1'b0) begin
      failures++; $display("[TB] FAIL r0_alu_consumed: got stall=%b, required 0", bus_if.alu_stall);
    end
    @(posedge clk); #1;
    bus_if.alu_valid = 1'b0;
    checks++;
    if (bus_if.rf_write_enable !== 1'b0) begin
      failures++; $display("[TB] FAIL r0_alu_no_write: got we=%b, required 0", bus_if.rf_write_enable);
    end
    bus_if.mc_valid = 1'b1;
    bus_if.mc_reg   = 5'd0;
    bus_if.mc_data  = 32'h1111;
    @(posedge clk); #1;
    bus_if.mc_valid = 1'b0;
    checks++;
    if (bus_if.fifo_count !== CNT_W'(1)) begin
      failures++; $display("[TB] FAIL r0_mc_buffered: got %0d, required 1", bus_if.fifo_count);
    end
    @(posedge clk); #1;
    checks++;
    if (bus_if.fifo_count !== CNT_W'(0) || bus_if.rf_write_enable !== 1'b0) begin
      failures++;
      $display("[TB] FAIL r0_mc_popped: got count=%0d we=%b, required count=0 we=0",
               bus_if.fifo_count, bus_if.rf_write_enable);
    end
  endtask

  task automatic test_sb_error_and_reset();
    bus_if.issue_valid = 1'b1;
    bus_if.issue_reg   = 5'd5;
    @(posedge clk); #1;
    checks++;
    if (bus_if.sb_error !== 1'b0) begin
      failures++; $display("[TB] FAIL sb_first_issue: got %b, required 0", bus_if.sb_error);
    end
    @(posedge clk); #1;
    bus_if.issue_valid = 1'b0;
    checks++;
    if (bus_if.sb_error !== 1'b1) begin
      failures++; $display("[TB] FAIL sb_double_issue: got %b, required 1", bus_if.sb_error);
    end
    repeat (3) @(posedge clk);
    #1;
    bus_if.query_reg_1 = 5'd5;
    #1;
    checks++;
    if (bus_if.sb_error !== 1'b1 || bus_if.busy_1 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL sb_sticky: got err=%b busy=%b, required err=1 busy=1", bus_if.sb_error, bus_if.busy_1);
    end
    for (int i = 0; i < 3; i++) begin
      bus_if.alu_valid = 1'b1;
      bus_if.alu_reg   = 5'(12 + i);
      bus_if.alu_data  = 32'hC000 + 32'(i);
      expQ.push_back(mkReq(5'(12 + i), 32'hC000 + 32'(i)));
      bus_if.mc_valid  = 1'b1;
      bus_if.mc_reg    = 5'(25 + i);
      bus_if.mc_data   = 32'hD000 + 32'(i);
      @(posedge clk); #1;
    end
    bus_if.alu_valid = 1'b0;
    bus_if.mc_valid  = 1'b0;
    checks++;
    if (bus_if.fifo_count !== CNT_W'(3)) begin
      failures++; $display("[TB] FAIL burst_count: got %0d, required 3", bus_if.fifo_count);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus_if.fifo_count !== CNT_W'(0) || bus_if.busy_1 !== 1'b0 || bus_if.rf_write_enable !== 1'b0 ||
        bus_if.sb_error !== 1'b0 || bus_if.mc_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_reset: got count=%0d busy=%b we=%b err=%b ready=%b, required 0 0 0 0 0",
               bus_if.fifo_count, bus_if.busy_1, bus_if.rf_write_enable, bus_if.sb_error, bus_if.mc_ready);
    end
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (bus_if.fifo_count !== CNT_W'(0) || expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL post_reset_discard: got count=%0d pending=%0d, required 0 0",
               bus_if.fifo_count, expQ.size());
    end
  endtask

`ifdef WB_BYPASS_EN
  task automatic test_bypass();
    bus_if.query_reg_1 = 5'd7;
    bus_if.alu_valid   = 1'b1;
    bus_if.alu_reg     = 5'd7;
    bus_if.alu_data    = 32'h55;
    expQ.push_back(mkReq(5'd7, 32'h55));
    @(posedge clk); #1;
    bus_if.alu_valid = 1'b0;
    checks++;
    if (bus_if.fwd_hit_1 !== 1'b1 || bus_if.fwd_data_1 !== 32'h55) begin
      failures++;
      $display("[TB] FAIL fwd_hit: got hit=%b data=%h, required hit=1 data=00000055",
               bus_if.fwd_hit_1, bus_if.fwd_data_1);
    end
    bus_if.query_reg_1 = 5'd0;
    bus_if.query_reg_2 = 5'd7;
    #1;
    checks++;
    if (bus_if.fwd_hit_1 !== 1'b0 || bus_if.fwd_hit_2 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL fwd_r0_and_port2: got hit1=%b hit2=%b, required hit1=0 hit2=1",
               bus_if.fwd_hit_1, bus_if.fwd_hit_2);
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting write-back arbiter bench");
    test_reset();
    test_alu_write();
    test_mc_scoreboard();
    test_back_to_back();
    test_starvation();
    test_reg_zero();
    test_sb_error_and_reset();
`ifdef WB_BYPASS_EN
    test_bypass();
`endif
    @(posedge clk); #1;
    checks++;
    if (expQ.size() != 0) begin
      failures++; $display("[TB] FAIL final_queue: got %0d pending writes, required 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
